// File: rtl/bcd_seg_scan_pkg.sv
// Shared constants for the BCD 7-segment scan display stage.
package bcd_seg_scan_pkg;

  // Display geometry: four digits plus a sign position.
  localparam int unsigned NumPos = 5;
  localparam int unsigned IdxW   = 3;

  // Field offsets inside the 17-bit {sign, thousands, hundreds, tens, ones} word.
  localparam int unsigned SignBit = 16;
  localparam int unsigned ThouLsb = 12;
  localparam int unsigned HundLsb = 8;
  localparam int unsigned TensLsb = 4;
  localparam int unsigned OnesLsb = 0;

  // Active-high segment patterns, bit order g..a.
  localparam logic [6:0] Seg0     = 7'h3F;
  localparam logic [6:0] Seg1     = 7'h06;
  localparam logic [6:0] Seg2     = 7'h5B;
  localparam logic [6:0] Seg3     = 7'h4F;
  localparam logic [6:0] Seg4     = 7'h66;
  localparam logic [6:0] Seg5     = 7'h6D;
  localparam logic [6:0] Seg6     = 7'h7D;
  localparam logic [6:0] Seg7     = 7'h07;
  localparam logic [6:0] Seg8     = 7'h7F;
  localparam logic [6:0] Seg9     = 7'h6F;
  localparam logic [6:0] SegE     = 7'h79;
  localparam logic [6:0] SegMinus = 7'h40;
  localparam logic [6:0] SegBlank = 7'h00;

  // Scan positions in the order they are lit.
  typedef enum logic [IdxW-1:0] {
    PosOnes = 3'd0,
    PosTens = 3'd1,
    PosHund = 3'd2,
    PosThou = 3'd3,
    PosSign = 3'd4
  } pos_e;

  // Extract one BCD digit starting at bit lsb.
  function automatic logic [3:0] bcd_digit(input logic [16:0] value, input int unsigned lsb);
    return value[lsb +: 4];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment decoder: BCD digit, blank and minus selects in,
// active-high g..a pattern out. Digits above 9 render as 'E'.
module seg7_decode
  import bcd_seg_scan_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       minus,
  output logic [6:0] pattern
);

  // Minus overrides blank; otherwise decode the digit.
  always_comb begin
    pattern = SegBlank;
    if (minus) begin
      pattern = SegMinus;
    end else if (!blank) begin
      case (digit)
        4'd0:    pattern = Seg0;
        4'd1:    pattern = Seg1;
        4'd2:    pattern = Seg2;
        4'd3:    pattern = Seg3;
        4'd4:    pattern = Seg4;
        4'd5:    pattern = Seg5;
        4'd6:    pattern = Seg6;
        4'd7:    pattern = Seg7;
        4'd8:    pattern = Seg8;
        4'd9:    pattern = Seg9;
        default: pattern = SegE;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Multiplexed 5-position 7-segment scanner fed by a BCD converter.
// Incoming values are held in a pending buffer and only copied to the
// displayed (active) buffer at a frame boundary, so a frame never tears.
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 50000,
  parameter bit          BLANK_EN = 1'b1,
  parameter bit          ACT_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bcd_vld,
  input  logic [16:0] bcd,
  output logic [7:0]  seg,
  output logic [4:0]  an,
  output logic        frame_start
);

  localparam int unsigned    DivW   = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  pos_e            idx_q, idx_d;
  logic [16:0]     active_q, active_d;
  logic [16:0]     pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic [6:0]      seg_q, seg_d;
  logic [4:0]      an_oh_q, an_oh_d;
  logic            frame_start_q, frame_start_d;

  logic            tick;
  logic            boundary;
  logic [3:0]      ones, tens, hund, thou;
  logic [3:0]      dec_digit;
  logic            dec_blank;
  logic            dec_minus;

  assign ones = bcd_digit(active_q, OnesLsb);
  assign tens = bcd_digit(active_q, TensLsb);
  assign hund = bcd_digit(active_q, HundLsb);
  assign thou = bcd_digit(active_q, ThouLsb);

  // Divider, scan index and double-buffer next state.
  always_comb begin
    tick     = (div_q == DivMax);
    boundary = tick && (idx_q == PosSign);
    div_d    = tick ? '0 : div_q + 1'b1;
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == PosSign) ? PosOnes : pos_e'(idx_q + 3'd1);
    end
    // A strobe on the boundary cycle lands in pending and waits a frame.
    pend_d     = bcd_vld ? bcd : pend_q;
    pend_vld_d = bcd_vld | (pend_vld_q & ~boundary);
    active_d   = (boundary && pend_vld_q) ? pend_q : active_q;
  end

  // Select the digit and blanking for the current scan position.
  always_comb begin
    dec_digit = 4'd0;
    dec_blank = 1'b0;
    dec_minus = 1'b0;
    an_oh_d   = 5'b00000;
    case (idx_q)
      PosOnes: begin
        dec_digit = ones;
        an_oh_d   = 5'b00001;
      end
      PosTens: begin
        dec_digit = tens;
        dec_blank = BLANK_EN && (tens == 4'd0) && (hund == 4'd0) && (thou == 4'd0);
        an_oh_d   = 5'b00010;
      end
      PosHund: begin
        dec_digit = hund;
        dec_blank = BLANK_EN && (hund == 4'd0) && (thou == 4'd0);
        an_oh_d   = 5'b00100;
      end
      PosThou: begin
        dec_digit = thou;
        dec_blank = BLANK_EN && (thou == 4'd0);
        an_oh_d   = 5'b01000;
      end
      PosSign: begin
        dec_minus = active_q[SignBit];
        dec_blank = ~active_q[SignBit];
        an_oh_d   = 5'b10000;
      end
      default: begin
        dec_blank = 1'b1;
      end
    endcase
    // Pulse when position 0 is about to be lit but is not lit yet.
    frame_start_d = (idx_q == PosOnes) && !an_oh_q[0];
  end

  seg7_decode u_seg7_decode (
    .digit   (dec_digit),
    .blank   (dec_blank),
    .minus   (dec_minus),
    .pattern (seg_d)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      idx_q         <= PosOnes;
      active_q      <= '0;
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      seg_q         <= '0;
      an_oh_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      seg_q         <= seg_d;
      an_oh_q       <= an_oh_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Polarity is a static choice; dp is always off.
  assign seg         = ACT_LOW ? ~{1'b0, seg_q} : {1'b0, seg_q};
  assign an          = ACT_LOW ? ~an_oh_q : an_oh_q;
  assign frame_start = frame_start_q;

endmodule
